// File: rtl/cv32e40p_sleep_pwr_ctrl_pkg.sv
// cv32e40p_sleep_pwr_ctrl_pkg: state encoding and parameter defaults for the sleep power controller
package cv32e40p_sleep_pwr_ctrl_pkg;
  typedef logic [3:0] pwr_state_e;
  localparam pwr_state_e PWR_ACTIVE  = 4'b0000;
  localparam pwr_state_e PWR_SETTLE  = 4'b0001;
  localparam pwr_state_e PWR_REQ_ON  = 4'b0010;
  localparam pwr_state_e PWR_REQ_OFF = 4'b1000;
  localparam pwr_state_e PWR_OFF     = 4'b1100;
  localparam int IDLE_CYCLES_DEF = 4;
  localparam int ACK_TIMEOUT_DEF = 255;
  localparam int CNT_W_DEF       = 32;
endpackage

// File: rtl/cv32e40p_sleep_pwr_ctrl_sat_counter.sv
// cv32e40p_sat_counter: saturating up-counter with clear priority over increment
// Ports: clk, rst_n (async active-low), clr (sync clear), inc (count enable), cnt (value)
module cv32e40p_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? '0 : (inc && !(&cnt)) ? cnt + WIDTH'(1) : cnt;
endmodule

// File: rtl/cv32e40p_sleep_pwr_ctrl.sv
// cv32e40p_sleep_pwr_ctrl: debounced sleep entry and four-phase power-off handshake with the SoC
// Ports: clk_ungated_i/rst_n free-running clock and async reset; core_sleep_i/wake_req_i from the
// sleep unit; wake_from_sleep_o gated wake back to it; pwr_req_o/pwr_ack_i SoC handshake;
// pwr_gated_o SoC confirmed off; ack_timeout_o/timeout_clr_i sticky timeout flag;
// sleep_cycles_o/sleep_cnt_clr_i saturating count of OFF cycles.
module cv32e40p_sleep_pwr_ctrl
  import cv32e40p_sleep_pwr_ctrl_pkg::*;
#(
  parameter int IDLE_CYCLES = IDLE_CYCLES_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk_ungated_i,
  input  logic             rst_n,
  input  logic             core_sleep_i,
  input  logic             wake_req_i,
  output logic             wake_from_sleep_o,
  output logic             pwr_req_o,
  input  logic             pwr_ack_i,
  output logic             pwr_gated_o,
  output logic             ack_timeout_o,
  input  logic             timeout_clr_i,
  output logic [CNT_W-1:0] sleep_cycles_o,
  input  logic             sleep_cnt_clr_i
);
  localparam int IW = IDLE_CYCLES > 1 ? $clog2(IDLE_CYCLES) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  if (IDLE_CYCLES < 1 || ACK_TIMEOUT < 1) begin : g_bad_param
    $error("cv32e40p_sleep_pwr_ctrl: IDLE_CYCLES and ACK_TIMEOUT must be >= 1");
  end
  pwr_state_e    state_q, state_d;
  logic [IW-1:0] idle_cnt;
  logic [TW-1:0] to_cnt;
  logic          leave, waiting, to_fire;
  always_comb begin
    leave   = wake_req_i | ~core_sleep_i;
    waiting = (state_q == PWR_REQ_OFF) | (state_q == PWR_REQ_ON);
    // timeout only counts while the awaited ack edge is still missing
    to_fire = waiting & (pwr_ack_i == (state_q == PWR_REQ_ON)) & (to_cnt == TW'(ACK_TIMEOUT - 1));
    state_d = PWR_ACTIVE;
    case (state_q)
      PWR_ACTIVE:  state_d = (core_sleep_i & ~wake_req_i) ? PWR_SETTLE : PWR_ACTIVE;
      PWR_SETTLE:  state_d = leave ? PWR_ACTIVE : (idle_cnt == IW'(IDLE_CYCLES - 1)) ? PWR_REQ_OFF : PWR_SETTLE;
      PWR_REQ_OFF: state_d = pwr_ack_i ? PWR_OFF : (leave | to_fire) ? PWR_REQ_ON : PWR_REQ_OFF;
      PWR_OFF:     state_d = leave ? PWR_REQ_ON : PWR_OFF;
      PWR_REQ_ON:  state_d = (~pwr_ack_i | to_fire) ? PWR_ACTIVE : PWR_REQ_ON;
      default:     state_d = PWR_ACTIVE;
    endcase
  end
  always_ff @(posedge clk_ungated_i or negedge rst_n)
    if (!rst_n) begin
      state_q       <= PWR_ACTIVE;
      idle_cnt      <= '0;
      to_cnt        <= '0;
      ack_timeout_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      idle_cnt      <= (state_q == PWR_SETTLE) ? idle_cnt + IW'(1) : '0;
      to_cnt        <= (state_d != state_q) ? '0 : to_cnt + TW'(waiting);
      ack_timeout_o <= to_fire | (ack_timeout_o & ~timeout_clr_i);
    end
  // dedicated encoding bits make the handshake outputs single-flop, glitch-free decodes
  assign pwr_req_o         = state_q[3];
  assign pwr_gated_o       = state_q[2];
  assign wake_from_sleep_o = wake_req_i & ~|state_q[3:1];
  cv32e40p_sat_counter #(.WIDTH(CNT_W)) u_sleep_cnt (
    .clk  (clk_ungated_i),
    .rst_n(rst_n),
    .clr  (sleep_cnt_clr_i),
    .inc  (state_q == PWR_OFF),
    .cnt  (sleep_cycles_o)
  );
endmodule

// File: tb/tb_cv32e40p_sleep_pwr_ctrl.sv
// tb_cv32e40p_sleep_pwr_ctrl: directed and random checks of the sleep power controller against a reference model
module tb_cv32e40p_sleep_pwr_ctrl;
  localparam int IC   = 4;
  localparam int AT   = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 0, rst_n = 0, cs = 0, wk = 0, ak = 0, tclr = 0, sclr = 0;
  logic wfs, preq, pg, ato;
  logic [CW-1:0] scyc;
  int errors = 0, checks = 0;
  // model: phase 0 awake, 1 debouncing, 2 asking off, 3 off, 4 asking on
  int ph = 0, seen = 0, waited = 0, cnt = 0;
  bit flag = 0;
  cv32e40p_sleep_pwr_ctrl #(.IDLE_CYCLES(IC), .ACK_TIMEOUT(AT), .CNT_W(CW)) dut (
    .clk_ungated_i    (clk),
    .rst_n            (rst_n),
    .core_sleep_i     (cs),
    .wake_req_i       (wk),
    .wake_from_sleep_o(wfs),
    .pwr_req_o        (preq),
    .pwr_ack_i        (ak),
    .pwr_gated_o      (pg),
    .ack_timeout_o    (ato),
    .timeout_clr_i    (tclr),
    .sleep_cycles_o   (scyc),
    .sleep_cnt_clr_i  (sclr)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic cmp();
    check("wake", 32'(wfs), 32'(wk && ph <= 1));
    check("req", 32'(preq), 32'(ph == 2 || ph == 3));
    check("gated", 32'(pg), 32'(ph == 3));
    check("timeout", 32'(ato), 32'(flag));
    check("cycles", 32'(scyc), cnt);
  endtask
  task automatic model();
    bit fire, off, leave;
    fire  = 0;
    off   = (ph == 3);
    leave = wk || !cs;
    case (ph)
      0: if (cs && !wk) begin ph = 1; seen = 1; end
      // the qualifying awake cycle plus IC debounce cycles precede the request
      1: if (leave) ph = 0; else begin seen++; if (seen == IC + 1) begin ph = 2; waited = 0; end end
      2: if (ak) ph = 3;
         else begin
           waited++;
           if (waited == AT) begin fire = 1; ph = 4; waited = 0; end
           else if (leave) begin ph = 4; waited = 0; end
         end
      3: if (leave) begin ph = 4; waited = 0; end
      default: if (!ak) ph = 0;
               else begin waited++; if (waited == AT) begin fire = 1; ph = 0; end end
    endcase
    cnt  = sclr ? 0 : (off && cnt < CMAX) ? cnt + 1 : cnt;
    flag = fire ? 1'b1 : tclr ? 1'b0 : flag;
  endtask
  task automatic step();
    #1 cmp();
    @(posedge clk);
    model();
    @(negedge clk);
  endtask
  task automatic cyc(input bit c, input bit w, input bit a, input bit t = 1'b0, input bit s = 1'b0);
    cs = c; wk = w; ak = a; tclr = t; sclr = s;
    step();
  endtask
  initial begin
    @(negedge clk);
    wk = 1;
    #1;
    check("rst_wake", 32'(wfs), 1);
    check("rst_req", 32'(preq), 0);
    check("rst_gated", 32'(pg), 0);
    check("rst_timeout", 32'(ato), 0);
    check("rst_cycles", 32'(scyc), 0);
    @(negedge clk);
    wk = 0; rst_n = 1;
    repeat (4) cyc(1, 0, 0);
    check("req_before", 32'(preq), 0);
    cyc(1, 0, 0);
    check("req_rise", 32'(preq), 1);
    check("gated_wait", 32'(pg), 0);
    cyc(1, 0, 0);
    cyc(1, 0, 1);
    check("gated_rise", 32'(pg), 1);
    repeat (3) cyc(1, 0, 1);
    cyc(1, 1, 1);
    check("req_fall", 32'(preq), 0);
    check("wake_held", 32'(wfs), 0);
    cyc(1, 1, 1);
    cyc(1, 1, 1);
    cyc(1, 1, 0);
    check("wake_resume", 32'(wfs), 1);
    cyc(0, 0, 0);
    repeat (3) cyc(1, 0, 0);
    cs = 1; wk = 1;
    #1 check("short_wake", 32'(wfs), 1);
    step();
    check("short_noreq", 32'(preq), 0);
    cyc(0, 0, 0);
    repeat (5) cyc(1, 0, 0);
    check("abort_req", 32'(preq), 1);
    cyc(1, 1, 0);
    check("abort_fall", 32'(preq), 0);
    cyc(1, 1, 0);
    check("abort_active", 32'(wfs), 1);
    check("abort_noto", 32'(ato), 0);
    cyc(0, 0, 0);
    repeat (12) cyc(1, 0, 0);
    check("to_early", 32'(ato), 0);
    check("to_still_req", 32'(preq), 1);
    cyc(1, 0, 0);
    check("to_set", 32'(ato), 1);
    check("to_req_drop", 32'(preq), 0);
    cyc(0, 0, 0);
    check("to_active", 32'(preq), 0);
    cyc(0, 0, 0, 1);
    check("to_clr", 32'(ato), 0);
    repeat (5) cyc(1, 0, 0);
    cyc(1, 0, 1);
    check("off_gated", 32'(pg), 1);
    repeat (20) cyc(1, 0, 1);
    check("sat", 32'(scyc), 15);
    cyc(1, 0, 1, 0, 1);
    check("cnt_clr", 32'(scyc), 0);
    cyc(1, 0, 1);
    check("cnt_resume", 32'(scyc), 1);
    #2 rst_n = 0;
    #1;
    check("arst_req", 32'(preq), 0);
    check("arst_gated", 32'(pg), 0);
    check("arst_cycles", 32'(scyc), 0);
    ph = 0; cnt = 0; flag = 0;
    @(negedge clk);
    cs = 0; wk = 0; ak = 0; rst_n = 1;
    step();
    check("arst_active", 32'(preq | pg), 0);
    repeat (3000) begin
      if ($urandom_range(0, 15) == 0) cs = ~cs;
      if ($urandom_range(0, 7) == 0) wk = ~wk;
      if (ak != (ph == 2 || ph == 3) && $urandom_range(0, 3) == 0) ak = ~ak;
      tclr = ($urandom_range(0, 19) == 0);
      sclr = ($urandom_range(0, 29) == 0);
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
